// File: rtl/dyn_partition_cycle_finder_pkg.sv
// rtl/dyn_partition_cycle_finder_pkg.sv - shared types, state helpers and Johnson phase decode
package dyn_partition_pkg;

   localparam int W_DEF      = 3;
   localparam int NFIELD_DEF = 2;
   localparam int JW_DEF     = 2;
   localparam int STATE_MAX  = 64;

   // Widest state the helpers handle; real states are zero-extended into it
   typedef logic [STATE_MAX-1:0] state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // State layout is {johnson, field[NFIELD-1], ..., field[0]}
   function automatic int state_w(input int w, input int nfield, input int jw);
      return nfield * w + jw;
   endfunction

   localparam int STATE_W = state_w(W_DEF, NFIELD_DEF, JW_DEF);

   // Phase 0 is all zeros; ones fill from the LSB, then zeros follow them in.
   // Codes outside the twisted-ring sequence decode to phase 0.
   function automatic int johnson_phase(input int jw, input logic [31:0] code);
      logic [31:0] mask;
      logic [31:0] c;
      int          ph;
      ph   = 0;
      mask = (jw >= 32) ? '1 : ((32'd1 << jw) - 32'd1);
      for (int p = 0; p < 64; p++) begin
         if (p < 2 * jw) begin
            if (p <= jw)
               c = (32'd1 << p) - 32'd1;
            else
               c = mask & ~((32'd1 << (p - jw)) - 32'd1);
            if (c == (code & mask))
               ph = p;
         end
      end
      return ph;
   endfunction

   function automatic logic [31:0] unpack_field(input state_t s, input int w, input int idx);
      return 32'((s >> (idx * w)) & ((64'd1 << w) - 64'd1));
   endfunction

   function automatic logic [31:0] unpack_johnson(input state_t s, input int w,
                                                  input int nfield, input int jw);
      return 32'((s >> (nfield * w)) & ((64'd1 << jw) - 64'd1));
   endfunction

   function automatic state_t pack_field(input state_t s, input int w, input int idx,
                                         input logic [31:0] v);
      state_t mask;
      mask = ((64'd1 << w) - 64'd1) << (idx * w);
      return (s & ~mask) | ((64'(v) << (idx * w)) & mask);
   endfunction

   function automatic state_t pack_johnson(input state_t s, input int w, input int nfield,
                                           input int jw, input logic [31:0] v);
      state_t mask;
      mask = ((64'd1 << jw) - 64'd1) << (nfield * w);
      return (s & ~mask) | ((64'(v) << (nfield * w)) & mask);
   endfunction

endpackage

// File: rtl/dyn_partition_cycle_finder_if.sv
// rtl/dyn_partition_cycle_finder_if.sv - request/result bundle; STATE_TRACE_EN adds the trace signals
interface dyn_partition_cycle_finder_if #(
   parameter int STATE_W = dyn_partition_pkg::STATE_W,
   parameter int CNT_W   = 16
);

   logic               start_i;
   logic [STATE_W-1:0] seed_i;
   logic               busy_o;
   logic               done_o;
   logic               found_o;
   logic               timeout_o;
   logic [CNT_W-1:0]   period_o;
   logic [CNT_W-1:0]   steps_o;

`ifdef STATE_TRACE_EN
   logic               trace_valid_o;
   logic [STATE_W-1:0] trace_state_o;

   modport master (
      output start_i, seed_i,
      input  busy_o, done_o, found_o, timeout_o, period_o, steps_o,
      input  trace_valid_o, trace_state_o
   );

   modport slave (
      input  start_i, seed_i,
      output busy_o, done_o, found_o, timeout_o, period_o, steps_o,
      output trace_valid_o, trace_state_o
   );
`else
   modport master (
      output start_i, seed_i,
      input  busy_o, done_o, found_o, timeout_o, period_o, steps_o
   );

   modport slave (
      input  start_i, seed_i,
      output busy_o, done_o, found_o, timeout_o, period_o, steps_o
   );
`endif

endinterface

// File: rtl/dyn_partition_cycle_finder_step.sv
// rtl/dyn_partition_cycle_finder_step.sv - combinational one-step transition f(s) of the partition system
module dyn_partition_step
   import dyn_partition_pkg::*;
#(
   parameter int W      = 3,
   parameter int NFIELD = 2,
   parameter int JW     = 2
) (
   input  logic [NFIELD*W+JW-1:0] cur_state,
   output logic [NFIELD*W+JW-1:0] nxt_state
);

   localparam int SW = NFIELD * W + JW;

   logic [JW-1:0] j;
   logic [JW-1:0] j_nxt;
   int            ph;
   int            active;

   assign j = cur_state[SW-1 -: JW];

   // Twisted-ring shift; a one-bit ring just toggles
   generate
      if (JW == 1) begin : g_ring1
         assign j_nxt = ~j;
      end else begin : g_ringn
         assign j_nxt = {j[JW-2:0], ~j[JW-1]};
      end
   endgenerate

   // Phase picks the single field that advances; the rest hold
   always_comb begin
      ph     = johnson_phase(JW, 32'(j));
      active = ph % NFIELD;
      nxt_state = cur_state;
      nxt_state[SW-1 -: JW] = j_nxt;
      for (int i = 0; i < NFIELD; i++) begin
         if (active == i)
            nxt_state[i*W +: W] = cur_state[i*W +: W] + 1'b1;
      end
   end

endmodule

// File: rtl/dyn_partition_cycle_finder.sv
// rtl/dyn_partition_cycle_finder.sv - Brent cycle finder over the partition system; STATE_TRACE_EN adds hare trace
module dyn_partition_cycle_finder
   import dyn_partition_pkg::*;
#(
   parameter int W         = 3,
   parameter int NFIELD    = 2,
   parameter int JW        = 2,
   parameter int CNT_W     = 16,
   parameter int MAX_STEPS = 4096
) (
   input logic                        clk,
   input logic                        rst_n,
   dyn_partition_cycle_finder_if.slave bus
);

   localparam int               SW      = state_w(W, NFIELD, JW);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   logic [1:0]       fsm;
   logic [SW-1:0]    tortoise;
   logic [SW-1:0]    hare;
   logic [SW-1:0]    step_cur;
   logic [SW-1:0]    step_nxt;
   logic [CNT_W-1:0] power;
   logic [CNT_W-1:0] lam;
   logic [CNT_W-1:0] steps;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] steps_res;
   logic             found;
   logic             timeout;
   logic             hit;
   logic             at_limit;

   // The single step instance serves f(seed) at load and f(hare) while running
   assign step_cur = (fsm == ST_IDLE) ? bus.seed_i : hare;

   dyn_partition_step #(
      .W      (W),
      .NFIELD (NFIELD),
      .JW     (JW)
   ) u_step (
      .cur_state (step_cur),
      .nxt_state (step_nxt)
   );

   assign hit      = (tortoise == hare);
   assign at_limit = (steps == MAX_CNT);

   // Search control: compare first, then either finish or advance the hare
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= ST_IDLE;
         tortoise  <= '0;
         hare      <= '0;
         power     <= '0;
         lam       <= '0;
         steps     <= '0;
         period    <= '0;
         steps_res <= '0;
         found     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (bus.start_i) begin
                  tortoise  <= bus.seed_i;
                  hare      <= step_nxt;
                  power     <= CNT_W'(1);
                  lam       <= CNT_W'(1);
                  steps     <= CNT_W'(1);
                  period    <= '0;
                  steps_res <= '0;
                  found     <= 1'b0;
                  timeout   <= 1'b0;
                  fsm       <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (hit) begin
                  found     <= 1'b1;
                  period    <= lam;
                  steps_res <= steps;
                  fsm       <= ST_DONE;
               end else if (at_limit) begin
                  timeout   <= 1'b1;
                  period    <= '0;
                  steps_res <= steps;
                  fsm       <= ST_DONE;
               end else begin
                  // A new power-of-two window restarts the length count at one
                  if (power == lam) begin
                     tortoise <= hare;
                     power    <= power << 1;
                     lam      <= CNT_W'(1);
                  end else begin
                     lam      <= lam + 1'b1;
                  end
                  hare  <= step_nxt;
                  steps <= steps + 1'b1;
               end
            end
            ST_DONE: begin
               fsm <= ST_IDLE;
            end
            default: begin
               fsm <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o    = (fsm == ST_RUN);
   assign bus.done_o    = (fsm == ST_DONE);
   assign bus.found_o   = found;
   assign bus.timeout_o = timeout;
   assign bus.period_o  = period;
   assign bus.steps_o   = steps_res;

`ifdef STATE_TRACE_EN
   logic          trace_valid;
   logic [SW-1:0] trace_state;

   // Registered view of the hare, flagged for every RUN cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trace_valid <= 1'b0;
         trace_state <= '0;
      end else begin
         trace_valid <= (fsm == ST_RUN);
         trace_state <= hare;
      end
   end

   assign bus.trace_valid_o = trace_valid;
   assign bus.trace_state_o = trace_state;
`else
   // Trace outputs are not part of this build
`endif

endmodule

// File: tb/tb_dyn_partition_cycle_finder.sv
// tb/tb_dyn_partition_cycle_finder.sv - scoreboard bench for the Brent cycle finder
module tb_dyn_partition_cycle_finder;
   import dyn_partition_pkg::*;

   typedef struct packed {
      logic        found;
      logic        timeout;
      logic [15:0] period;
      logic [15:0] steps;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt [3];

   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   logic [7:0] m_cur;
   logic [7:0] m_nxt;

   always #5 clk = ~clk;

   dyn_partition_cycle_finder_if #(.STATE_W(8), .CNT_W(16)) if0 ();
   dyn_partition_cycle_finder_if #(.STATE_W(2), .CNT_W(16)) if1 ();
   dyn_partition_cycle_finder_if #(.STATE_W(8), .CNT_W(16)) if2 ();

   dyn_partition_cycle_finder #(.W(3), .NFIELD(2), .JW(2), .CNT_W(16), .MAX_STEPS(4096))
      u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   dyn_partition_cycle_finder #(.W(1), .NFIELD(1), .JW(1), .CNT_W(16), .MAX_STEPS(4096))
      u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   dyn_partition_cycle_finder #(.W(3), .NFIELD(2), .JW(2), .CNT_W(16), .MAX_STEPS(8))
      u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   dyn_partition_step #(.W(3), .NFIELD(2), .JW(2)) u_model (.cur_state(m_cur), .nxt_state(m_nxt));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic fo, input logic to, input logic [15:0] per,
                               input logic [15:0] stp);
      exp_t e;
      e.found   = fo;
      e.timeout = to;
      e.period  = per;
      e.steps   = stp;
      return e;
   endfunction

   function automatic int qsize(input int which);
      case (which)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   // Pops the oldest expected result for one instance and compares it
   task automatic score(input int which, input logic [31:0] fo, input logic [31:0] to,
                        input logic [31:0] per, input logic [31:0] stp, input logic [31:0] bsy);
      exp_t e;
      logic have;
      have = 1'b0;
      e    = '0;
      case (which)
         0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      done_cnt[which]++;
      if (!have) begin
         n_checks++;
         n_fail++;
         $display("FAIL u%0d done_o: pulse with no pending request", which);
      end else begin
         check($sformatf("u%0d found_o", which),   fo,  32'(e.found));
         check($sformatf("u%0d timeout_o", which), to,  32'(e.timeout));
         check($sformatf("u%0d period_o", which),  per, 32'(e.period));
         check($sformatf("u%0d steps_o", which),   stp, 32'(e.steps));
         check($sformatf("u%0d busy_o at done", which), bsy, 32'd0);
      end
   endtask

   // Result monitors, one per instance
   always @(negedge clk)
      if (if0.done_o) score(0, 32'(if0.found_o), 32'(if0.timeout_o), 32'(if0.period_o),
                            32'(if0.steps_o), 32'(if0.busy_o));
   always @(negedge clk)
      if (if1.done_o) score(1, 32'(if1.found_o), 32'(if1.timeout_o), 32'(if1.period_o),
                            32'(if1.steps_o), 32'(if1.busy_o));
   always @(negedge clk)
      if (if2.done_o) score(2, 32'(if2.found_o), 32'(if2.timeout_o), 32'(if2.period_o),
                            32'(if2.steps_o), 32'(if2.busy_o));

`ifdef STATE_TRACE_EN
   logic [7:0] tr_exp [32];
   logic [7:0] tr_x;
   int         tr_idx   = 0;
   logic       trace_on = 1'b0;

   always @(negedge clk)
      if (trace_on && if0.trace_valid_o && tr_idx < 32) begin
         check($sformatf("trace_state_o[%0d]", tr_idx), 32'(if0.trace_state_o), 32'(tr_exp[tr_idx]));
         tr_idx++;
      end
`endif

   // Reference Brent search over the bench's own step instance
   task automatic model_brent(input logic [7:0] seed, output logic [15:0] per,
                              output logic [15:0] stp);
      logic [7:0] t;
      logic [7:0] h;
      int power;
      int lam;
      int n;
      t = seed;
      m_cur = seed;
      #1;
      h = m_nxt;
      power = 1;
      lam = 1;
      n = 1;
      while (t != h && n < 4096) begin
         if (power == lam) begin
            t = h;
            power = power * 2;
            lam = 0;
         end
         m_cur = h;
         #1;
         h = m_nxt;
         lam++;
         n++;
      end
      per = 16'(lam);
      stp = 16'(n);
   endtask

   task automatic start0(input logic [7:0] seed);
      @(negedge clk);
      if0.seed_i  = seed;
      if0.start_i = 1'b1;
      @(negedge clk);
      if0.start_i = 1'b0;
   endtask

   task automatic wait_drain(input int which, input int budget);
      int i;
      i = 0;
      while (qsize(which) != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check($sformatf("u%0d results drained", which), 32'(qsize(which)), 32'd0);
   endtask

   task automatic check_idle0(input string tag);
      check({tag, " busy_o"},    32'(if0.busy_o),    32'd0);
      check({tag, " done_o"},    32'(if0.done_o),    32'd0);
      check({tag, " found_o"},   32'(if0.found_o),   32'd0);
      check({tag, " timeout_o"}, 32'(if0.timeout_o), 32'd0);
      check({tag, " period_o"},  32'(if0.period_o),  32'd0);
      check({tag, " steps_o"},   32'(if0.steps_o),   32'd0);
`ifdef STATE_TRACE_EN
      check({tag, " trace_valid_o"}, 32'(if0.trace_valid_o), 32'd0);
      check({tag, " trace_state_o"}, 32'(if0.trace_state_o), 32'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 ns");
      $fatal(1);
   end

   initial begin
      int         lat;
      int         i;
      logic       seen;
      logic [15:0] per;
      logic [15:0] stp;
      state_t     s;
      logic [7:0] seed_a;

      done_cnt[0] = 0;
      done_cnt[1] = 0;
      done_cnt[2] = 0;
      if0.start_i = 1'b0; if0.seed_i = '0;
      if1.start_i = 1'b0; if1.seed_i = '0;
      if2.start_i = 1'b0; if2.seed_i = '0;
      m_cur = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle0("reset");
      rst_n = 1'b1;

      // Seed 0, defaults: period 16, hare caught at x31, start->done 32 cycles
      q0.push_back(mk(1'b1, 1'b0, 16'd16, 16'd31));
      @(negedge clk);
      if0.seed_i  = 8'h00;
      if0.start_i = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         if0.start_i = 1'b0;
         lat++;
         if (lat == 1) check("t1 busy_o after accept", 32'(if0.busy_o), 32'd1);
         if (if0.done_o) seen = 1'b1;
      end
      check("t1 start to done latency", 32'(lat), 32'd32);
      @(negedge clk);
      check("t1 busy_o after done", 32'(if0.busy_o), 32'd0);
      check("t1 done_o one cycle", 32'(if0.done_o), 32'd0);
      check("t1 found_o held", 32'(if0.found_o), 32'd1);
      check("t1 period_o held", 32'(if0.period_o), 32'd16);

      // Smallest system: state flips between 00 and 11, period 2 after 3 steps
      q1.push_back(mk(1'b1, 1'b0, 16'd2, 16'd3));
      @(negedge clk);
      if1.seed_i  = 2'b00;
      if1.start_i = 1'b1;
      @(negedge clk);
      if1.start_i = 1'b0;
      wait_drain(1, 50);

      // MAX_STEPS=8 stops before the 16-cycle is closed
      q2.push_back(mk(1'b0, 1'b1, 16'd0, 16'd8));
      @(negedge clk);
      if2.seed_i  = 8'h00;
      if2.start_i = 1'b1;
      @(negedge clk);
      if2.start_i = 1'b0;
      wait_drain(2, 50);

      // Seed with Johnson code 01 and nonzero fields, expected from the model
      s = '0;
      s = pack_field(s, 3, 0, 32'd2);
      s = pack_field(s, 3, 1, 32'd5);
      s = pack_johnson(s, 3, 2, 2, 32'd1);
      seed_a = 8'(s);
      check("t4 seed packing", 32'(seed_a), 32'h6A);
      model_brent(seed_a, per, stp);
      q0.push_back(mk(1'b1, 1'b0, per, stp));
      start0(seed_a);
      wait_drain(0, 100);

      // Second start mid-run and a start during DONE are both dropped
      q0.push_back(mk(1'b1, 1'b0, 16'd16, 16'd31));
      start0(8'h00);
      repeat (3) @(negedge clk);
      if0.seed_i  = seed_a;
      if0.start_i = 1'b1;
      @(negedge clk);
      if0.start_i = 1'b0;
      i = 0;
      while (!if0.done_o && i < 100) begin
         @(negedge clk);
         i++;
      end
      check("t5 done_o seen", 32'(if0.done_o), 32'd1);
      if0.start_i = 1'b1;
      @(negedge clk);
      if0.start_i = 1'b0;
      check("t5 start in DONE ignored", 32'(if0.busy_o), 32'd0);
      check("t5 period_o held", 32'(if0.period_o), 32'd16);
      repeat (40) @(negedge clk);

      // Reset mid-run: outputs clear, no done_o
      start0(8'h00);
      repeat (8) @(negedge clk);
      check("t6 busy_o before reset", 32'(if0.busy_o), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle0("t6 after reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t6 still idle", 32'(if0.busy_o), 32'd0);

      // Fresh start after the abort completes normally
`ifdef STATE_TRACE_EN
      tr_x = seed_a;
      for (int k = 0; k < 31; k++) begin
         m_cur = tr_x;
         #1;
         tr_x = m_nxt;
         tr_exp[k] = tr_x;
      end
      tr_idx   = 0;
      trace_on = 1'b1;
`endif
      q0.push_back(mk(1'b1, 1'b0, 16'd16, 16'd31));
      start0(seed_a);
      wait_drain(0, 100);
      repeat (2) @(negedge clk);
`ifdef STATE_TRACE_EN
      trace_on = 1'b0;
      check("t6 trace samples", 32'(tr_idx), 32'd31);
`endif

      check("u0 done_o pulses", 32'(done_cnt[0]), 32'd4);
      check("u1 done_o pulses", 32'(done_cnt[1]), 32'd1);
      check("u2 done_o pulses", 32'(done_cnt[2]), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
